// File: rtl/boot_message_sender_pkg.sv
// Shared core and message-service types for the boot message sender: tile/thread
// widths, host and service message layouts, and the sender's FSM state encoding.
`ifndef THREAD_NUMB
`define THREAD_NUMB 4
`endif
`ifndef TILE_COUNT
`define TILE_COUNT 4
`endif

package boot_message_sender_pkg;

    localparam int THREAD_NUMB    = `THREAD_NUMB;
    localparam int MAX_TILES      = `TILE_COUNT;
    localparam int THREAD_ID_W    = $clog2(THREAD_NUMB);
    // Tile ids are one bit wider than strictly needed so that out-of-range ids can be expressed.
    localparam int TILE_ID_W      = $clog2(MAX_TILES) + 1;
    localparam int ADDR_W         = 32;
    localparam int SERVICE_DATA_W = 64;

    typedef logic [TILE_ID_W-1:0]   tile_id_t;
    typedef logic [MAX_TILES-1:0]   tile_mask_t;
    typedef logic [ADDR_W-1:0]      address_t;
    typedef logic [THREAD_NUMB-1:0] thread_mask_t;
    typedef logic [THREAD_ID_W-1:0] thread_id_t;

    typedef enum logic [1:0] {
        BOOT_COMMAND  = 2'd0,
        ENABLE_THREAD = 2'd1
    } host_message_id_t;

    typedef enum logic [1:0] {
        HOST        = 2'd0,
        INSTRUCTION = 2'd1,
        SYNC        = 2'd2
    } service_message_type_t;

    typedef struct packed {
        host_message_id_t message;
        logic             hi_job_valid;
        address_t         hi_job_pc;
        thread_id_t       hi_job_thread_id;
        thread_mask_t     hi_thread_en;
    } host_message_t;

    typedef struct packed {
        service_message_type_t     message_type;
        tile_id_t                  source;
        logic [SERVICE_DATA_W-1:0] data;
    } service_message_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SCAN        = 2'd1,
        SEND_JOB    = 2'd2,
        SEND_ENABLE = 2'd3
    } bms_state_t;

    function automatic logic [SERVICE_DATA_W-1:0] host_to_service_data(input host_message_t msg);
        return SERVICE_DATA_W'(msg);
    endfunction

endpackage

// File: rtl/boot_message_sender_thread_mask_scanner.sv
// Selects one bit of a thread mask by index and reports whether the index is the last thread.
module thread_mask_scanner
    import boot_message_sender_pkg::*;
(
    input  thread_mask_t i_mask,
    input  thread_id_t   i_index,
    output logic         o_bit_set,
    output logic         o_last,
    output thread_id_t   o_index_inc
);

    logic [THREAD_NUMB-1:0] w_select;

    genvar gi;
    generate
        for (gi = 0; gi < THREAD_NUMB; gi++) begin : g_select
            assign w_select[gi] = (i_index == THREAD_ID_W'(gi));
        end
    endgenerate

    assign o_bit_set   = |(w_select & i_mask);
    assign o_last      = w_select[THREAD_NUMB-1];
    assign o_index_inc = i_index + THREAD_ID_W'(1);

endmodule

// File: rtl/boot_message_sender.sv
// Turns a host boot request into one BOOT_COMMAND per set thread-mask bit followed by
// a single ENABLE_THREAD, delivered to the requested tile over the service network.
module boot_message_sender
    import boot_message_sender_pkg::*;
#(
    parameter int TILE_ID    = 0,
    parameter int TILE_COUNT = `TILE_COUNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             boot_req_valid,
    output logic             boot_req_ready,
    input  tile_id_t         boot_req_tile_id,
    input  thread_mask_t     boot_req_thread_mask,
    input  address_t         boot_req_pc,
    input  logic             network_available,
    output service_message_t message_out,
    output logic             message_out_valid,
    output tile_mask_t       destination_valid,
    output logic             busy,
    output logic             boot_req_error
);

    bms_state_t   r_state;
    tile_id_t     r_tile_id;
    thread_mask_t r_mask;
    address_t     r_pc;
    thread_id_t   r_index;
    logic         r_error;

    bms_state_t    w_state_next;
    thread_id_t    w_index_next;
    logic          w_latch;
    logic          w_error_next;
    logic          w_tile_bad;
    host_message_t w_host_msg;

    thread_mask_t  w_scan_mask;
    thread_id_t    w_scan_index;
    logic          w_bit_set;
    logic          w_last;
    thread_id_t    w_index_inc;

    // In IDLE the scanner looks at the incoming mask so bit 0 is examined in the accept
    // cycle; this is what lets the first BOOT_COMMAND leave in the very next cycle.
    assign w_scan_mask  = (r_state == IDLE) ? boot_req_thread_mask : r_mask;
    assign w_scan_index = (r_state == IDLE) ? '0 : r_index;
    assign w_tile_bad   = int'(boot_req_tile_id) >= TILE_COUNT;

    thread_mask_scanner u_scanner (
        .i_mask      (w_scan_mask),
        .i_index     (w_scan_index),
        .o_bit_set   (w_bit_set),
        .o_last      (w_last),
        .o_index_inc (w_index_inc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_tile_id <= '0;
            r_mask    <= '0;
            r_pc      <= '0;
            r_index   <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            r_error <= w_error_next;
            if (w_latch) begin
                r_tile_id <= boot_req_tile_id;
                r_mask    <= boot_req_thread_mask;
                r_pc      <= boot_req_pc;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_index_next      = r_index;
        w_latch           = 1'b0;
        w_error_next      = 1'b0;
        boot_req_ready    = 1'b0;
        message_out_valid = 1'b0;
        w_host_msg        = '0;

        case (r_state)
            IDLE: begin
                boot_req_ready = reset;
                if (boot_req_valid) begin
                    if (w_tile_bad) begin
                        w_error_next = 1'b1;
                    end else begin
                        w_latch = 1'b1;
                        if (w_bit_set) begin
                            w_state_next = SEND_JOB;
                            w_index_next = '0;
                        end else if (w_last) begin
                            w_state_next = SEND_ENABLE;
                            w_index_next = '0;
                        end else begin
                            w_state_next = SCAN;
                            w_index_next = w_index_inc;
                        end
                    end
                end
            end

            SCAN: begin
                if (w_bit_set) begin
                    w_state_next = SEND_JOB;
                end else if (w_last) begin
                    w_state_next = SEND_ENABLE;
                end else begin
                    w_index_next = w_index_inc;
                end
            end

            SEND_JOB: begin
                w_host_msg.message          = BOOT_COMMAND;
                w_host_msg.hi_job_valid     = 1'b1;
                w_host_msg.hi_job_pc        = r_pc;
                w_host_msg.hi_job_thread_id = r_index;
                if (network_available) begin
                    message_out_valid = 1'b1;
                    if (w_last) begin
                        w_state_next = SEND_ENABLE;
                    end else begin
                        w_state_next = SCAN;
                        w_index_next = w_index_inc;
                    end
                end
            end

            SEND_ENABLE: begin
                w_host_msg.message      = ENABLE_THREAD;
                w_host_msg.hi_thread_en = r_mask;
                if (network_available) begin
                    message_out_valid = 1'b1;
                    w_state_next      = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        message_out              = '0;
        message_out.message_type = HOST;
        message_out.source       = TILE_ID_W'(TILE_ID);
        message_out.data         = host_to_service_data(w_host_msg);
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_TILES; gi++) begin : g_dest
            assign destination_valid[gi] = message_out_valid && (r_tile_id == TILE_ID_W'(gi));
        end
    endgenerate

    assign busy           = (r_state != IDLE);
    assign boot_req_error = r_error;

endmodule

// File: tb/tb_boot_message_sender.sv
// Directed bench for boot_message_sender: stimulus pushes expected messages into a
// scoreboard queue, and a negedge monitor pops and compares every emitted message.
`timescale 1ns/1ps
module tb_boot_message_sender;
    import boot_message_sender_pkg::*;

    localparam int TB_TILE_ID = 3;

    typedef struct {
        service_message_t msg;
        tile_mask_t       dest;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             boot_req_valid = 1'b0;
    logic             boot_req_ready;
    tile_id_t         boot_req_tile_id = '0;
    thread_mask_t     boot_req_thread_mask = '0;
    address_t         boot_req_pc = '0;
    logic             network_available = 1'b1;
    service_message_t message_out;
    logic             message_out_valid;
    tile_mask_t       destination_valid;
    logic             busy;
    logic             boot_req_error;

    int   checks = 0;
    int   errors = 0;
    int   msg_count = 0;
    int   err_pulses = 0;
    bit   prev_err = 1'b0;
    bit   toggle_mode = 1'b0;
    exp_t sb[$];

    boot_message_sender #(.TILE_ID(TB_TILE_ID), .TILE_COUNT(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .boot_req_valid       (boot_req_valid),
        .boot_req_ready       (boot_req_ready),
        .boot_req_tile_id     (boot_req_tile_id),
        .boot_req_thread_mask (boot_req_thread_mask),
        .boot_req_pc          (boot_req_pc),
        .network_available    (network_available),
        .message_out          (message_out),
        .message_out_valid    (message_out_valid),
        .destination_valid    (destination_valid),
        .busy                 (busy),
        .boot_req_error       (boot_req_error)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            network_available = toggle_mode ? ~network_available : 1'b1;
        end
    end

    function automatic service_message_t wrap(input host_message_t h);
        service_message_t s;
        s = '0;
        s.message_type = HOST;
        s.source = tile_id_t'(TB_TILE_ID);
        s.data[$bits(host_message_t)-1:0] = h;
        return s;
    endfunction

    task automatic push_boot(input thread_id_t tid, input address_t pc, input tile_mask_t dest);
        exp_t e;
        host_message_t h;
        h = '0;
        h.message = BOOT_COMMAND;
        h.hi_job_valid = 1'b1;
        h.hi_job_pc = pc;
        h.hi_job_thread_id = tid;
        e.msg = wrap(h);
        e.dest = dest;
        sb.push_back(e);
    endtask

    task automatic push_enable(input thread_mask_t m, input tile_mask_t dest);
        exp_t e;
        host_message_t h;
        h = '0;
        h.message = ENABLE_THREAD;
        h.hi_thread_en = m;
        e.msg = wrap(h);
        e.dest = dest;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Presents a request and holds it until accepted (bounded), leaving at posedge+1.
    task automatic send_req(input tile_id_t t, input thread_mask_t m, input address_t pc);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        @(posedge clk);
        #1;
        boot_req_valid = 1'b1;
        boot_req_tile_id = t;
        boot_req_thread_mask = m;
        boot_req_pc = pc;
        while (!done) begin
            @(negedge clk);
            check("ready_excl_busy", 64'(boot_req_ready && busy), 64'd0);
            if (boot_req_ready) begin
                done = 1'b1;
            end else if (++waited > 400) begin
                errors++;
                $display("FAIL accept_timeout got=not_accepted exp=accepted");
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        boot_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int waited;
        waited = 0;
        while ((busy || sb.size() != 0) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_idle_ready"}, 64'(boot_req_ready), 64'd1);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("reset_valid", 64'(message_out_valid), 64'd0);
                check("reset_dest", 64'(destination_valid), 64'd0);
            end else begin
                if (message_out_valid) begin
                    msg_count++;
                    check("valid_needs_net", 64'(network_available), 64'd1);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_msg got=%h exp=none", message_out);
                    end else begin
                        e = sb.pop_front();
                        checks++;
                        if (message_out !== e.msg) begin
                            errors++;
                            $display("FAIL msg_content got=%h exp=%h", message_out, e.msg);
                        end
                        check("msg_dest", 64'(destination_valid), 64'(e.dest));
                    end
                end else if (destination_valid !== '0) begin
                    checks++;
                    errors++;
                    $display("FAIL dest_when_invalid got=%h exp=0", destination_valid);
                end
                if (boot_req_error) begin
                    err_pulses++;
                    if (prev_err) begin
                        checks++;
                        errors++;
                        $display("FAIL err_pulse_width got=2+ exp=1");
                    end
                end
            end
            prev_err = boot_req_error;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int base_msgs;
        int base_errs;
        int waited;

        // Reset state, with a request pending to prove ready is held low
        boot_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(boot_req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_error", 64'(boot_req_error), 64'd0);
        boot_req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(boot_req_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);

        // Tile 2, mask 0101, pc 0x400, network always available; first message next cycle
        push_boot(2'd0, 32'h400, 4'b0100);
        push_boot(2'd2, 32'h400, 4'b0100);
        push_enable(4'b0101, 4'b0100);
        send_req(4'd2, 4'b0101, 32'h400);
        @(negedge clk);
        check("min_latency_valid", 64'(message_out_valid), 64'd1);
        wait_idle("t36");

        // All-zero mask to tile 1
        push_enable(4'b0000, 4'b0010);
        send_req(4'd1, 4'b0000, 32'h1000);
        wait_idle("t37");

        // Out-of-range tile: error pulse, no messages, still ready
        base_msgs = msg_count;
        base_errs = err_pulses;
        send_req(4'd4, 4'b1111, 32'h2000);
        repeat (3) @(negedge clk);
        check("bad_tile_pulses", 64'(err_pulses - base_errs), 64'd1);
        check("bad_tile_no_msgs", 64'(msg_count - base_msgs), 64'd0);
        check("bad_tile_ready", 64'(boot_req_ready), 64'd1);
        check("bad_tile_busy", 64'(busy), 64'd0);

        // All ones with network toggling every cycle
        toggle_mode = 1'b1;
        push_boot(2'd0, 32'h1234_5678, 4'b1000);
        push_boot(2'd1, 32'h1234_5678, 4'b1000);
        push_boot(2'd2, 32'h1234_5678, 4'b1000);
        push_boot(2'd3, 32'h1234_5678, 4'b1000);
        push_enable(4'b1111, 4'b1000);
        send_req(4'd3, 4'b1111, 32'h1234_5678);
        wait_idle("t39");
        toggle_mode = 1'b0;
        @(posedge clk);

        // Second request during busy is back-pressured until the first ENABLE_THREAD
        push_boot(2'd0, 32'hA000, 4'b0001);
        push_boot(2'd1, 32'hA000, 4'b0001);
        push_enable(4'b0011, 4'b0001);
        send_req(4'd0, 4'b0011, 32'hA000);
        boot_req_valid = 1'b1;
        boot_req_tile_id = 4'd1;
        boot_req_thread_mask = 4'b1000;
        boot_req_pc = 32'hB000;
        @(negedge clk);
        check("bp_busy", 64'(busy), 64'd1);
        check("bp_ready", 64'(boot_req_ready), 64'd0);
        push_boot(2'd3, 32'hB000, 4'b0010);
        push_enable(4'b1000, 4'b0010);
        send_req(4'd1, 4'b1000, 32'hB000);
        wait_idle("t40");

        // Reset mid-sequence after the first BOOT_COMMAND
        push_boot(2'd0, 32'hC000, 4'b0100);
        push_boot(2'd1, 32'hC000, 4'b0100);
        push_boot(2'd2, 32'hC000, 4'b0100);
        push_boot(2'd3, 32'hC000, 4'b0100);
        push_enable(4'b1111, 4'b0100);
        base_msgs = msg_count;
        send_req(4'd2, 4'b1111, 32'hC000);
        waited = 0;
        while (msg_count == base_msgs && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("abort_first_seen", 64'(msg_count - base_msgs), 64'd1);
        reset = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_more_msgs", 64'(msg_count - base_msgs), 64'd1);
        push_boot(2'd0, 32'hD000, 4'b0100);
        push_boot(2'd1, 32'hD000, 4'b0100);
        push_boot(2'd2, 32'hD000, 4'b0100);
        push_boot(2'd3, 32'hD000, 4'b0100);
        push_enable(4'b1111, 4'b0100);
        send_req(4'd2, 4'b1111, 32'hD000);
        wait_idle("t41");

        check("total_err_pulses", 64'(err_pulses), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_message_sender.md
BOOT_MESSAGE_SENDER -- requirements
Module: boot_message_sender

Interface
REQ-001 SHALL have parameter TILE_ID, default 0, giving the source tile of emitted messages.
REQ-002 SHALL have parameter TILE_COUNT, default `TILE_COUNT, giving the number of addressable tiles.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 boot_req_valid  input  1  host boot request present.
REQ-006 boot_req_ready  output  1  request accepted when valid && ready.
REQ-007 boot_req_tile_id  input  tile_id_t  destination tile.
REQ-008 boot_req_thread_mask  input  `THREAD_NUMB  threads to start.
REQ-009 boot_req_pc  input  address_t  start PC shared by all masked threads.
REQ-010 network_available  input  1  service network can take one message this cycle.
REQ-011 message_out  output  service_message_t  outgoing service message.
REQ-012 message_out_valid  output  1  message_out valid; one message per asserted cycle.
REQ-013 destination_valid  output  tile_mask_t  one-hot destination mask.
REQ-014 busy  output  1  high while any state other than IDLE is active.
REQ-015 boot_req_error  output  1  one-cycle pulse on rejected request.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, SEND_JOB, SEND_ENABLE.
REQ-017 IDLE: boot_req_ready=1; on accept, latch tile_id, mask and pc; clear thread index; go to SCAN.
REQ-018 Requests with tile_id >= TILE_COUNT SHALL be consumed (ready=1), pulse boot_req_error for 1 cycle, and remain in IDLE without emitting messages.
REQ-019 SCAN: examine latched mask bit at thread index, one bit per cycle; if set go to SEND_JOB; if clear, increment index; after bit `THREAD_NUMB-1 go to SEND_ENABLE.
REQ-020 SEND_JOB: when network_available=1, drive message_out_valid=1 with host_message_t {message=BOOT_COMMAND, hi_job_valid=1, hi_job_pc=latched pc, hi_job_thread_id=index}, increment index, and return to SCAN, or go to SEND_ENABLE after the last index; otherwise hold with valid=0.
REQ-021 SEND_ENABLE: when network_available=1, drive message_out_valid=1 with {message=ENABLE_THREAD, hi_thread_en=latched mask}, then go to IDLE; otherwise hold with valid=0.
REQ-022 message_out_valid SHALL be asserted only in a cycle where network_available=1.
REQ-023 message_out.message_type SHALL be HOST; data SHALL carry host_message_t zero-extended to the service data width.
REQ-024 destination_valid SHALL equal 1 << latched tile_id whenever message_out_valid=1, and 0 otherwise.
REQ-025 An all-zero mask SHALL emit no BOOT_COMMAND, only ENABLE_THREAD with a zero mask.
REQ-026 For n set mask bits, exactly n BOOT_COMMANDs SHALL be emitted in ascending thread-id order, followed by exactly one ENABLE_THREAD.
REQ-027 Minimum latency SHALL be: request accepted in cycle N, first message in cycle N+1 (for mask bit 0 set and network available).
REQ-028 boot_req_ready SHALL be 0 outside IDLE; new requests SHALL be back-pressured, never dropped.
REQ-029 The thread index counter SHALL be $clog2(`THREAD_NUMB) bits wide and SHALL NOT wrap within a request.

Reset
REQ-030 While reset=0, state=IDLE, index=0, and latched fields=0.
REQ-031 While reset=0, message_out_valid=0, destination_valid=0, busy=0, boot_req_error=0, and boot_req_ready=0.
REQ-032 Reset asserted mid-sequence SHALL abort immediately with no further messages; after reset release the block SHALL restart in IDLE.

Structure
REQ-033 host_message_t, the host message enumeration (BOOT_COMMAND, ENABLE_THREAD) and the HOST service type SHALL come from the shared message-service defines package; no local redefinition.
REQ-034 tile_id_t, tile_mask_t and address_t SHALL come from the shared core defines.
REQ-035 Mask-bit selection MAY live in one sub-module, thread_mask_scanner; it is otherwise inline.

Verification
REQ-036 tile_id=2, mask=4'b0101, pc=0x400, network always available -> BOOT_COMMAND thread 0 pc 0x400, BOOT_COMMAND thread 2 pc 0x400, then ENABLE_THREAD 0101, all with destination_valid=0b0100.
REQ-037 mask=0, tile_id=1 -> exactly one ENABLE_THREAD with mask 0 to tile 1; busy deasserts afterwards.
REQ-038 tile_id=TILE_COUNT -> boot_req_error 1-cycle pulse, no message_out_valid, ready remains 1.
REQ-039 mask=all ones, network_available toggling 1/0 every cycle -> `THREAD_NUMB BOOT_COMMANDs then one ENABLE; valid never high while available=0.
REQ-040 Second request presented during busy -> ready=0 until IDLE; the second sequence starts only after the first ENABLE_THREAD.
REQ-041 Reset pulled low after the first BOOT_COMMAND of mask 4'b1111 -> no further messages; a new request after release is served from thread 0.
